// File: rtl/pc_stack_unit_pkg.sv
// pc_stack_unit_pkg: PC source and branch source encodings shared with sequence control
package pc_stack_unit_pkg;
  typedef enum logic [1:0] {
    PC_SRC_BRA  = 2'b00,
    PC_SRC_STK  = 2'b01,
    PC_SRC_RST  = 2'b10,
    PC_SRC_HOLD = 2'b11
  } pc_src_e;
  localparam logic BRA_SRC_REL = 1'b0;
  localparam logic BRA_SRC_ABS = 1'b1;
endpackage

// File: rtl/pc_stack_unit_return_stack.sv
// return_stack: LIFO of return addresses with sticky overflow/underflow flags
module return_stack #(
  parameter int AddrWidth  = 8,
  parameter int StackDepth = 8
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        push_n,
  input  logic                        pop_n,
  input  logic                        clr_n,
  input  logic [AddrWidth-1:0]        din,
  output logic [AddrWidth-1:0]        top,
  output logic [$clog2(StackDepth):0] depth,
  output logic                        full,
  output logic                        empty,
  output logic                        ovf,
  output logic                        unf
);
  localparam int PW = $clog2(StackDepth);
  localparam int DW = PW + 1;
  logic [AddrWidth-1:0] mem [StackDepth];
  logic [PW-1:0] top_idx, wr_idx;
  logic do_push, do_pop, do_swap, set_ovf, set_unf;
  assign full    = depth == DW'(StackDepth);
  assign empty   = depth == '0;
  assign top_idx = PW'(depth - 1'b1);
  assign do_push = !push_n && pop_n && !full;
  assign do_pop  = !pop_n && push_n && !empty;
  assign do_swap = !push_n && !pop_n && !empty;
  assign set_ovf = !push_n && pop_n && full;
  assign set_unf = !pop_n && empty;
  assign wr_idx  = do_swap ? top_idx : PW'(depth);
  assign top     = empty ? '0 : mem[top_idx];
  // Entries are deliberately left uninitialised; depth alone defines validity.
  always_ff @(posedge Clk)
    if (do_push || do_swap) mem[wr_idx] <= din;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      depth <= depth + DW'(do_push) - DW'(do_pop);
      ovf   <= clr_n && (ovf || set_ovf);
      unf   <= clr_n && (unf || set_unf);
    end
endmodule

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with branch adder, PC source mux and return stack
module pc_stack_unit
  import pc_stack_unit_pkg::*;
#(
  parameter int          AddrWidth   = 8,
  parameter int          OffsetWidth = 10,
  parameter int          StackDepth  = 8,
  parameter int unsigned ResetVector = 0
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        PC_Rst,
  input  logic                        PC_Ld,
  input  logic                        PC_Inc,
  input  logic [1:0]                  PC_Src,
  input  logic                        BRA_Src,
  input  logic                        STK_Ld,
  input  logic                        STK_Pop,
  input  logic [OffsetWidth-1:0]      IR_Offset,
  input  logic [AddrWidth-1:0]        REG_Data,
  output logic [AddrWidth-1:0]        PC_Out,
  output logic [AddrWidth-1:0]        STK_Top,
  output logic [$clog2(StackDepth):0] STK_Depth,
  output logic                        STK_Full,
  output logic                        STK_Empty,
  output logic                        STK_Ovf,
  output logic                        STK_Unf
);
  localparam logic [AddrWidth-1:0] RV = AddrWidth'(ResetVector);
  logic [AddrWidth-1:0] bra_tgt, src_mux, pc_nxt;
  // Size cast sign-extends a narrow offset and truncates a wide one, both modulo 2^AddrWidth.
  assign bra_tgt = BRA_Src == BRA_SRC_ABS ? REG_Data : PC_Out + AddrWidth'($signed(IR_Offset));
  assign src_mux = PC_Src == PC_SRC_BRA ? bra_tgt :
                   PC_Src == PC_SRC_STK ? STK_Top :
                   PC_Src == PC_SRC_RST ? RV : PC_Out;
  assign pc_nxt  = !PC_Rst ? RV : !PC_Ld ? src_mux : !PC_Inc ? PC_Out + 1'b1 : PC_Out;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) PC_Out <= RV;
    else PC_Out <= pc_nxt;
  return_stack #(.AddrWidth(AddrWidth), .StackDepth(StackDepth)) u_stack (
    .Clk    (Clk),
    .Reset  (Reset),
    .push_n (STK_Ld),
    .pop_n  (STK_Pop),
    .clr_n  (PC_Rst),
    .din    (PC_Out),
    .top    (STK_Top),
    .depth  (STK_Depth),
    .full   (STK_Full),
    .empty  (STK_Empty),
    .ovf    (STK_Ovf),
    .unf    (STK_Unf)
  );
endmodule
